// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, shifts one
// command byte out on device clock falling edges and checks the device acknowledge.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | lines released, waiting for tx_start
// S_INHIBIT   | host holds PS/2 clock low for INHIBIT_CYCLES
// S_REQ       | clock and data both low for one cycle (start bit)
// S_XFER      | clock released, data bits driven on each device falling edge
// S_ACK       | waiting for falling edge 11 to sample the device acknowledge
// S_WAIT_IDLE | waiting for both lines to return high
// S_DONE      | one-cycle completion pulse, then back to idle
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic             clk_s1, clk_s2, clk_s3;
    logic             data_s1, data_s2;
    logic [7:0]       tx_byte;
    logic             par_q;
    logic [3:0]       bit_cnt;
    logic             data_q;
    logic             err_q;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic fe;
    logic accept;
    logic wd_active;
    logic timeout;

    assign fe        = clk_s3 & ~clk_s2;
    assign accept    = (state == S_IDLE) && tx_start;
    assign wd_active = (state == S_XFER) || (state == S_ACK) || (state == S_WAIT_IDLE);
    assign timeout   = wd_active && (wd_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx_busy     = 1'b1;
        tx_done     = 1'b0;
        tx_error    = 1'b0;
        case (state)
            S_IDLE: begin
                tx_busy = 1'b0;
                if (tx_start) state_nxt = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                if (inh_cnt == '0) state_nxt = S_REQ;
            end
            S_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                state_nxt   = S_XFER;
            end
            S_XFER: begin
                // a watchdog expiry must drop the line in the same cycle
                ps2_data_oe = data_q & ~timeout;
                if (timeout) state_nxt = S_DONE;
                else if (fe && (bit_cnt == 4'd9)) state_nxt = S_ACK;
            end
            S_ACK: begin
                if (timeout) state_nxt = S_DONE;
                else if (fe) state_nxt = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (timeout) state_nxt = S_DONE;
                else if (clk_s2 && data_s2) state_nxt = S_DONE;
            end
            S_DONE: begin
                tx_done   = 1'b1;
                tx_error  = err_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            data_s1 <= 1'b1;
            data_s2 <= 1'b1;
            tx_byte <= '0;
            par_q   <= 1'b0;
            bit_cnt <= '0;
            data_q  <= 1'b0;
            err_q   <= 1'b0;
            inh_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            clk_s3  <= clk_s2;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;

            if (accept) begin
                tx_byte <= tx_data;
                par_q   <= ~^tx_data;
                bit_cnt <= '0;
                data_q  <= 1'b1;
                err_q   <= 1'b0;
                inh_cnt <= INH_LOAD;
            end

            if ((state == S_INHIBIT) && (inh_cnt != '0)) begin
                inh_cnt <= inh_cnt - INH_W'(1);
            end

            if (state == S_REQ) begin
                wd_cnt <= WD_LOAD;
            end else if (wd_active) begin
                if (fe) wd_cnt <= WD_LOAD;
                else if (wd_cnt != '0) wd_cnt <= wd_cnt - WD_W'(1);
            end

            // the line is pulled low for a 0 bit, so the enable is the inverted bit
            if ((state == S_XFER) && fe && !timeout) begin
                bit_cnt <= bit_cnt + 4'd1;
                if (bit_cnt < 4'd8) data_q <= ~tx_byte[bit_cnt[2:0]];
                else if (bit_cnt == 4'd8) data_q <= ~par_q;
                else data_q <= 1'b0;
            end

            if ((state == S_ACK) && fe) begin
                err_q <= data_s2;
            end

            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host; a monitor
// checks every tx_done against a queue of expected results pushed at stimulus time.
module tb_ps2_host_tx;

    localparam int INH = 8;
    localparam int TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_error    (tx_error)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       err;
        logic       has_data;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail = 0;
    int         done_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_par = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: every completion pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (!rst && tx_done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_error", tx_error, mon_e.err);
                chk("done_oes", {ps2_clk_oe, ps2_data_oe}, 0);
                chk("done_lines_idle", {ps2_clk_in, ps2_data_in}, 3);
                if (mon_e.has_data) begin
                    chk("rx_byte", rx_byte, mon_e.data);
                    chk("rx_parity", rx_par, mon_e.par);
                end
            end
        end else if (!rst && tx_error === 1'b1) begin
            chk("error_without_done", 1, 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic p, input logic err,
                        input logic has_data, input bit push);
        int g = 0;
        while (tx_busy && g < 500) begin
            tick();
            g++;
        end
        chk("idle_before_start", tx_busy, 0);
        tx_data  = d;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        if (push) exp_q.push_back('{data: d, par: p, err: err, has_data: has_data});
    endtask

    task automatic wait_release();
        int g = 0;
        while (!(tx_busy && !ps2_clk_oe) && g < 200) begin
            tick();
            g++;
        end
        chk("release_seen", (g < 200) ? 1 : 0, 1);
    endtask

    // full device frame; oe1 is the hand-computed data enable after the first edge (~bit0)
    task automatic dev_frame(input bit ack, input logic oe1);
        logic [9:0] bits;
        wait_release();
        chk("start_bit", ps2_data_in, 0);
        tick(4);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            if (i == 0) begin
                tick(2);
                chk("edge_latency_hold", ps2_data_oe, 1);
                tick(1);
                chk("edge_latency_bit0", ps2_data_oe, oe1);
                tick(7);
            end else begin
                tick(10);
            end
            bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
            tick(10);
        end
        rx_byte = bits[7:0];
        rx_par  = bits[8];
        chk("stop_bit", bits[9], 1);
        if (ack) dev_data_low = 1'b1;
        tick(3);
        dev_clk_low = 1'b1;
        tick(10);
        dev_clk_low = 1'b0;
        tick(5);
        dev_data_low = 1'b0;
        tick(5);
    endtask

    initial begin
        int cnt;
        tick(3);
        chk("reset_clk_oe", ps2_clk_oe, 0);
        chk("reset_data_oe", ps2_data_oe, 0);
        chk("reset_busy", tx_busy, 0);
        chk("reset_done", tx_done, 0);
        chk("reset_error", tx_error, 0);
        rst = 1'b0;
        tick(2);

        // normal 0xED with inhibit length check
        send(8'hED, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("busy_after_accept", tx_busy, 1);
        cnt = 0;
        while (ps2_clk_oe && !ps2_data_oe && cnt < 100) begin
            tick();
            cnt++;
        end
        chk("inhibit_cycles", cnt, INH);
        chk("req_oes", {ps2_clk_oe, ps2_data_oe}, 3);
        dev_frame(1'b1, 1'b0);

        // parity coverage
        send(8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        dev_frame(1'b1, 1'b1);
        send(8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        dev_frame(1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
        dev_frame(1'b1, 1'b0);

        // no acknowledge
        send(8'hF4, 1'b0, 1'b1, 1'b1, 1'b1);
        dev_frame(1'b0, 1'b1);

        // silent device: watchdog expiry
        send(8'h5A, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_release();
        cnt = 0;
        while (ps2_data_oe && cnt < 300) begin
            tick();
            cnt++;
        end
        chk("silent_hold_cycles", cnt, TMO);
        chk("silent_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        tick();
        chk("silent_done_pulse", {tx_done, tx_error}, 3);
        tick();
        chk("silent_busy", tx_busy, 0);

        // start while busy must be ignored
        send(8'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
        fork
            dev_frame(1'b1, 1'b1);
            begin
                tick(60);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
        join
        tick(200);
        chk("busy_start_idle", tx_busy, 0);

        // reset after edge 5, then a fresh transfer
        send(8'h33, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_release();
        tick(4);
        for (int i = 0; i < 5; i++) begin
            dev_clk_low = 1'b1;
            tick(10);
            if (i < 4) begin
                dev_clk_low = 1'b0;
                tick(10);
            end
        end
        rst = 1'b1;
        tick();
        chk("abort_oes", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("abort_busy", tx_busy, 0);
        rst = 1'b0;
        dev_clk_low = 1'b0;
        tick(100);
        send(8'h12, 1'b1, 1'b0, 1'b1, 1'b1);
        dev_frame(1'b1, 1'b1);
        tick(50);

        chk("done_count", done_cnt, 8);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as 0xED for set-LEDs or 0xFF for reset. The byte goes out over the same open-drain clock/data pair the keyboard receiver listens on. The block runs on the system clock and drives the lines only through active-high output enables; the pad level applies the pull-down. It sits alongside the keyboard receiver, and the receiver must be ignored while `tx_busy` is high.

## Interface
- `INHIBIT_CYCLES`, default 5000: system cycles the PS/2 clock is held low before the request (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum system cycles allowed between device clock falling edges, and from clock release to the first edge (15 ms at 50 MHz).
- `clk`  in  1: system clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ps2_clk_in`  in  1: PS/2 clock pad level (asynchronous).
- `ps2_data_in`  in  1: PS/2 data pad level (asynchronous).
- `ps2_clk_oe`  out  1: 1 = pull PS/2 clock low; 0 = release.
- `ps2_data_oe`  out  1: 1 = pull PS/2 data low; 0 = release.
- `tx_data`  in  8: byte to send; captured on the accepted `tx_start`.
- `tx_start`  in  1: single-cycle request; accepted only while idle.
- `tx_busy`  out  1: transfer in progress.
- `tx_done`  out  1: one-cycle pulse at the end of every accepted transfer.
- `tx_error`  out  1: one-cycle pulse, coincident with `tx_done`, when the transfer failed.

## Operation
- Input conditioning:
  - 2-FF synchronizers on `ps2_clk_in` and `ps2_data_in`.
  - A third register on the clock path for edge detection.
  - Falling edge `fe` = previous synced value 1 and current synced value 0.
- On `tx_start` in IDLE:
  - Latch `tx_data`.
  - Compute odd parity: `par` = ~^`tx_data`.
  - Clear the edge counter `n`.
- State machine:
  - **IDLE**: both OEs 0; `tx_busy` 0.
  - **INHIBIT**: `ps2_clk_oe`=1, `ps2_data_oe`=0 for exactly INHIBIT_CYCLES cycles.
  - **REQ** (1 cycle): both OEs 1. This is the start bit.
  - **XFER**: `ps2_clk_oe`=0 and `ps2_data_oe` stays 1. On each `fe`, increment `n` and drive the next bit, with `ps2_data_oe` = ~bit:
    - `n`=1..8: `tx_data[n-1]`, LSB first.
    - `n`=9: `par`.
    - `n`=10: stop bit, `ps2_data_oe`=0.
  - **ACK**: at `fe` number 11, sample the synced data. 0 = acknowledged; 1 = error.
  - **WAIT_IDLE**: wait for synced clock=1 and data=1.
  - **DONE** (1 cycle): pulse `tx_done`, plus `tx_error` if the transfer failed, then return to IDLE.
- Watchdog:
  - The counter reloads on every `fe` and on entry to XFER.
  - It runs in XFER, ACK and WAIT_IDLE.
  - If it reaches TIMEOUT_CYCLES: release both OEs the same cycle, go to DONE with error.
- A missing ack goes through WAIT_IDLE before DONE, subject to the watchdog.
- `tx_start` while busy is ignored; no queueing.
- `tx_busy`:
  - 1 from the cycle after acceptance through DONE inclusive.
  - 0 in the cycle after DONE, when `tx_start` may be accepted again.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_busy`=0, `tx_done`=0, `tx_error`=0, state IDLE, synchronizers 1.
- Reset mid-transfer releases both lines on the next clock edge. No `tx_done` is produced for the aborted byte.
- Start to clock release: INHIBIT_CYCLES + 1 cycles after the acceptance cycle.
- Edge response: a pad falling edge changes `ps2_data_oe` 3 system cycles later, well inside the ≥30 µs device low phase.
- `tx_done` follows the ack sample plus the time for both lines to return high, plus 1 cycle.
- `fe` in REQ or INHIBIT is ignored; the device cannot clock while the host holds clock low.

## Test plan
- **Normal 0xED** (INHIBIT_CYCLES=8, device model clocks at 20-cycle period, acks low):
  - Required: data bits after start 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Required: `tx_done`=1 with `tx_error`=0.
  - Required: `ps2_clk_oe` held exactly 8 cycles before REQ.
- **Parity coverage** (0x00, 0xFF, 0x01, with acks):
  - Required: sampled parity bits 1, 1, 0.
  - Required: received byte equals the sent byte.
- **No ack** (send 0xF4, device leaves data high at edge 11):
  - Required: `tx_done` and `tx_error` pulse together after the lines idle.
  - Required: both OEs 0.
- **Device silent** (TIMEOUT_CYCLES=100, no clock edges after release):
  - Required: exactly 100 cycles after release, OEs 0, then a `tx_done`+`tx_error` pulse and `tx_busy`=0.
- **Start while busy**: assert `tx_start` with 0x55 during XFER of 0xAA.
  - Required: only 0xAA is transmitted.
  - Required: a single `tx_done`.
- **Reset mid-transfer**: assert `rst` after edge 5.
  - Required: OEs 0 and `tx_busy` 0 next cycle; no `tx_done`.
  - Required: a fresh 0x12 transfer afterwards completes normally.
